nios_system_mul_sequencer: RTL and testbench
============================================

# nios_system_mul_sequencer

Multi-cycle multiply controller that computes 32x32 products (low word, or high word unsigned/mixed/signed) by sequencing four 16x16 partial products through a single registered 16x16 unsigned multiplier. It sits between the Nios II execute stage and the shared DSP multiplier, trading latency for one DSP block. Operands and result move over valid/ready handshakes.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 16x16 multiplier.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer idle; high exactly when state is IDLE.
- `req_op`  in  2  operation select:
  - 0: MUL, low 32 bits.
  - 1: MULXUU, high 32 bits, both operands unsigned.
  - 2: MULXSU, high 32 bits, src1 signed, src2 unsigned.
  - 3: MULXSS, high 32 bits, both operands signed.
- `req_src1`  in  32  operand A.
- `req_src2`  in  32  operand B.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_result`  out  32  product word selected by `req_op`.

## Operation
- Request accept: on `req_valid & req_ready`, capture `req_op`, `req_src1` and `req_src2`; clear the 64-bit accumulator.
- State sequence for MULX ops: IDLE→PP0→PP1→PP2→PP3→ACC→FIX→RESP→IDLE.
- State sequence for MUL: IDLE→PP0→PP1→PP2→ACC→RESP→IDLE.
- Multiplier issue, one product per state:
  - PP0: a_lo*b_lo.
  - PP1: a_hi*b_lo.
  - PP2: a_lo*b_hi.
  - PP3: a_hi*b_hi.
- The product of each issue returns one cycle later. The state after an issue adds that product to the accumulator:
  - p0 at shift 0.
  - p1 and p2 at shift 16.
  - p3 at shift 32.
- All accumulator adds are unsigned, modulo 2^64.
- FIX applies sign correction to the high word, modulo 2^32:
  - MULXSU: subtract B if A[31].
  - MULXSS: subtract B if A[31]; also subtract A if B[31].
  - MULXUU: no change.
- RESP drives `resp_valid`=1 and `resp_result`:
  - MUL: acc[31:0].
  - MULX ops: acc[63:32].
- `resp_result` holds stable while `resp_valid & ~resp_ready`. The transfer returns the block to IDLE.
- Input changes after acceptance have no effect.

## Timing
- Accept occurs at edge t0.
- MULX latency: `resp_valid` rises at t0+7.
- MUL latency: `resp_valid` rises at t0+5.
- `req_ready` is low from t0+1 until the cycle after the response transfer. A new request cannot be accepted in the same cycle as the response transfer.
- Maximum throughput is one op per 8 cycles (MULX) or 6 cycles (MUL) when `resp_ready` is held high.
- Reset values:
  - State IDLE.
  - `req_ready`=1.
  - `resp_valid`=0.
  - `resp_result`=0.
  - Accumulator and captured operands 0.
  - Multiplier output register 0.
- Reset mid-operation aborts immediately. No response is produced for the aborted op. The first request after reset release is accepted normally.
- `resp_ready` high while `resp_valid`=0 has no effect.
- Asserting `req_valid` while busy has no effect; the request stays pending until `req_ready`.

## Configuration
- Macro `NIOS_MUL_SEQ_MULX_EN`.
- Defined: all four ops are supported as above.
- Undefined:
  - States PP3, ACC-after-PP3 and FIX are not built, and `req_op` is ignored.
  - Every request executes as MUL with 5-cycle latency.
  - The accumulator shrinks to 32 bits.

## Structure
- Package `nios_mul_seq_pkg` holds:
  - The op enum (MUL, MULXUU, MULXSU, MULXSS).
  - The state enum.
  - The constants MUL_LATENCY=5 and MULX_LATENCY=7.
- Sub-module `nios_system_mul16_cell`:
  - 16x16 unsigned multiplier with a 32-bit registered output and async clear.
  - Sole DSP instance.
  - Instantiated once.

## Test plan
- MUL, A=0x0001_0003, B=0x0002_0005 -> `resp_result`=0x000B_000F, with `resp_valid` at t0+5.
- MULXUU, A=B=0xFFFF_FFFF -> 0xFFFF_FFFE at t0+7.
- MULXSS, A=B=0xFFFF_FFFF -> 0x0000_0000.
- MULXSU, A=0xFFFF_FFFF, B=0x0000_0002 -> 0xFFFF_FFFF.
- Backpressure: `resp_ready` low for 3 cycles after `resp_valid` -> result and valid held. `req_ready` stays 0 until the cycle after the transfer, and the next request is accepted one cycle later.
- `reset` pulsed in PP2 -> `resp_valid` never asserts for that op, and `req_ready`=1 during reset. The next MUL 7*9 returns 63.

Source files
------------

// File: rtl/nios_mul_seq_pkg.sv
// Shared types and constants for the sequenced 32x32 multiplier.
// NIOS_MUL_SEQ_MULX_EN selects the high-word (MULX) ops and the 64-bit accumulator.
package nios_mul_seq_pkg;

   typedef enum logic [1:0] {
      OpMul   = 2'd0,
      OpMulxuu = 2'd1,
      OpMulxsu = 2'd2,
      OpMulxss = 2'd3
   } mul_op_e;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPp0  = 3'd1,
      StPp1  = 3'd2,
      StPp2  = 3'd3,
      StPp3  = 3'd4,
      StAcc  = 3'd5,
      StFix  = 3'd6,
      StResp = 3'd7
   } state_e;

   localparam int unsigned MUL_LATENCY  = 5;
   localparam int unsigned MULX_LATENCY = 7;

`ifdef NIOS_MUL_SEQ_MULX_EN
   localparam int unsigned ACC_W = 64;
`else
   localparam int unsigned ACC_W = 32;
`endif

   function automatic logic is_mulx(input mul_op_e op);
      return op != OpMul;
   endfunction

   // Amount to subtract from the unsigned high word to get the signed/mixed high word.
   function automatic logic [31:0] high_word_correction(input mul_op_e op,
                                                        input logic [31:0] a,
                                                        input logic [31:0] b);
      logic [31:0] corr;
      corr = '0;
      if ((op == OpMulxsu || op == OpMulxss) && a[31]) begin
         corr = corr + b;
      end
      if (op == OpMulxss && b[31]) begin
         corr = corr + a;
      end
      return corr;
   endfunction

endpackage

// File: rtl/nios_system_mul16_cell.sv
// 16x16 unsigned multiplier with registered 32-bit product; the block's only DSP.
module nios_system_mul16_cell (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   logic [31:0] prod_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod_q <= '0;
      end else begin
         prod_q <= 32'(a) * 32'(b);
      end
   end

   assign p = prod_q;

endmodule

// File: rtl/nios_system_mul_sequencer.sv
// Multi-cycle 32x32 multiply controller built around one registered 16x16 multiplier.
// Define NIOS_MUL_SEQ_MULX_EN to build the MULX high-word ops; otherwise every op is MUL.
module nios_system_mul_sequencer
   import nios_mul_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result
);

   state_e           state_q, state_d;
   logic [31:0]      src1_q, src2_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [15:0]      mul_a, mul_b;
   logic [31:0]      mul_p;
   logic             accept;

`ifdef NIOS_MUL_SEQ_MULX_EN
   mul_op_e          op_q;
`else
   logic             unused_req_op;
   assign unused_req_op = ^req_op;
`endif

   assign accept = req_valid && (state_q == StIdle);

   nios_system_mul16_cell u_mul16 (
      .clk   (clk),
      .reset (reset),
      .a     (mul_a),
      .b     (mul_b),
      .p     (mul_p)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         acc_q   <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
`ifdef NIOS_MUL_SEQ_MULX_EN
         op_q    <= OpMul;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         if (accept) begin
            src1_q <= req_src1;
            src2_q <= req_src2;
`ifdef NIOS_MUL_SEQ_MULX_EN
            op_q   <= mul_op_e'(req_op);
`endif
         end
      end
   end

   // Each state issues one partial product and accumulates the one issued the cycle before.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mul_a      = '0;
      mul_b      = '0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;

      case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               acc_d   = '0;
               state_d = StPp0;
            end
         end

         StPp0: begin
            mul_a   = src1_q[15:0];
            mul_b   = src2_q[15:0];
            state_d = StPp1;
         end

         StPp1: begin
            acc_d   = acc_q + ACC_W'(mul_p);
            mul_a   = src1_q[31:16];
            mul_b   = src2_q[15:0];
            state_d = StPp2;
         end

         StPp2: begin
            acc_d   = acc_q + (ACC_W'(mul_p) << 16);
            mul_a   = src1_q[15:0];
            mul_b   = src2_q[31:16];
`ifdef NIOS_MUL_SEQ_MULX_EN
            state_d = is_mulx(op_q) ? StPp3 : StAcc;
`else
            state_d = StAcc;
`endif
         end

`ifdef NIOS_MUL_SEQ_MULX_EN
         StPp3: begin
            acc_d   = acc_q + (ACC_W'(mul_p) << 16);
            mul_a   = src1_q[31:16];
            mul_b   = src2_q[31:16];
            state_d = StAcc;
         end

         StAcc: begin
            if (is_mulx(op_q)) begin
               acc_d   = acc_q + (ACC_W'(mul_p) << 32);
               state_d = StFix;
            end else begin
               acc_d   = acc_q + (ACC_W'(mul_p) << 16);
               state_d = StResp;
            end
         end

         StFix: begin
            acc_d[63:32] = acc_q[63:32] - high_word_correction(op_q, src1_q, src2_q);
            state_d      = StResp;
         end
`else
         StAcc: begin
            acc_d   = acc_q + (ACC_W'(mul_p) << 16);
            state_d = StResp;
         end
`endif

         StResp: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // The accumulator is frozen in StResp, so the result holds under backpressure.
`ifdef NIOS_MUL_SEQ_MULX_EN
   assign resp_result = (op_q == OpMul) ? acc_q[31:0] : acc_q[63:32];
`else
   assign resp_result = acc_q;
`endif

endmodule

// File: tb/tb_nios_system_mul_sequencer.sv
// Directed bench for nios_system_mul_sequencer: arithmetic reference model plus literal checks.
// Follows NIOS_MUL_SEQ_MULX_EN: with it undefined every op is expected to behave as MUL.
module tb_nios_system_mul_sequencer;

`ifdef NIOS_MUL_SEQ_MULX_EN
   localparam bit MULX_EN = 1'b1;
`else
   localparam bit MULX_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;

   int checks   = 0;
   int failures = 0;
   int accept_wait;

   nios_system_mul_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result straight from 64-bit signed/unsigned arithmetic.
   function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
      logic [63:0] xa, xb, p;
      xa = {32'b0, a};
      xb = {32'b0, b};
      if (!MULX_EN || op == 2'd0) begin
         p = xa * xb;
         return p[31:0];
      end
      if (op != 2'd1) xa = {{32{a[31]}}, a};
      if (op == 2'd3) xb = {{32{b[31]}}, b};
      p = xa * xb;
      return p[63:32];
   endfunction

   function automatic int model_latency(input logic [1:0] op);
      return (MULX_EN && op != 2'd0) ? 7 : 5;
   endfunction

   // Transaction-level model: busy from accept until the response transfer.
   logic        m_busy;
   int          m_k;
   int          m_lat;
   logic [31:0] m_exp;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_k    <= 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy <= 1'b1;
            m_k    <= 1;
            m_lat  <= model_latency(req_op);
            m_exp  <= model_result(req_op, req_src1, req_src2);
         end
      end else if (m_k == m_lat) begin
         if (resp_ready) m_busy <= 1'b0;
      end else begin
         m_k <= m_k + 1;
      end
   end

   always @(negedge clk) begin
      logic exp_ready, exp_valid;
      exp_ready = reset || !m_busy;
      exp_valid = !reset && m_busy && (m_k == m_lat);
      check("cyc_req_ready", 32'(req_ready), 32'(exp_ready));
      check("cyc_resp_valid", 32'(resp_valid), 32'(exp_valid));
      if (exp_valid) check("cyc_resp_result", resp_result, m_exp);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Issue one op and return in the cycle where resp_valid is first seen.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int n;
      int cyc;
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      n = 0;
      while (!req_ready && n < 50) begin
         step();
         n++;
      end
      accept_wait = n;
      if (!req_ready) check({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_src1  = $urandom;
      req_src2  = $urandom;
      cyc = 1;
      while (!resp_valid && cyc < 20) begin
         step();
         cyc++;
      end
      check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({name, "_result"}, resp_result, exp_res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_op     = 2'd0;
      req_src1   = '0;
      req_src2   = '0;
      resp_ready = 1'b1;
      #1;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_resp_result", resp_result, 32'h0);
      step();
      step();
      reset = 1'b0;
      step();

      run_op("mul_basic", 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5);
      step();
`ifdef NIOS_MUL_SEQ_MULX_EN
      run_op("mulxuu_ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7);
      step();
      run_op("mulxss_ones", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7);
      step();
      run_op("mulxsu_neg1x2", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 7);
      step();
      run_op("mulxss_minmin", 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7);
      step();
`else
      run_op("mulxuu_as_mul", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5);
      step();
      run_op("mulxss_as_mul", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5);
      step();
      run_op("mulxsu_as_mul", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 5);
      step();
      run_op("mulxss_as_mul2", 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 5);
      step();
`endif
      run_op("mul_mix", 2'd0, 32'hDEAD_BEEF, 32'h1234_5678,
             model_result(2'd0, 32'hDEAD_BEEF, 32'h1234_5678), 5);
      step();
      run_op("mulxsu_mix", 2'd2, 32'h9ABC_DEF0, 32'h1234_5678,
             model_result(2'd2, 32'h9ABC_DEF0, 32'h1234_5678), model_latency(2'd2));
      step();

      // Backpressure: consumer stalls three cycles, then accepts.
      resp_ready = 1'b0;
      run_op("bp_op", 2'd3, 32'hFFFF_FFFE, 32'h0000_0003,
             model_result(2'd3, 32'hFFFF_FFFE, 32'h0000_0003), model_latency(2'd3));
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_valid_held", 32'(resp_valid), 32'd1);
         check("bp_result_held", resp_result,
               model_result(2'd3, 32'hFFFF_FFFE, 32'h0000_0003));
         check("bp_req_ready_low", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      step();
      check("bp_ready_after_xfer", 32'(req_ready), 32'd1);
      check("bp_valid_after_xfer", 32'(resp_valid), 32'd0);
      run_op("bp_next", 2'd0, 32'h0000_0100, 32'h0000_0010, 32'h0000_1000, 5);
      check("bp_next_accept_wait", 32'(accept_wait), 32'd0);
      step();

      // Reset pulsed while the op sits in PP2 aborts it without a response.
      req_valid = 1'b1;
      req_op    = 2'd0;
      req_src1  = 32'd5;
      req_src2  = 32'd6;
      step();
      req_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      #1;
      check("rst_mid_req_ready", 32'(req_ready), 32'd1);
      check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      step();
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (resp_valid) seen++;
      end
      check("rst_no_resp", 32'(seen), 32'd0);
      run_op("post_rst_7x9", 2'd0, 32'd7, 32'd9, 32'd63, 5);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
